mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Sequential front end that drives a 4-to-1 multiplexer: latches a 4-bit word with a valid/ready handshake and presents it on the mux data inputs.
- Steps the 2-bit select through all four positions, holding each for a programmable dwell time, so the mux output emits the word serially.
- Pulses a sample strobe once per position so the downstream stage can capture the mux output, then signals completion.

Parameters:
- DWELL, 1, clock cycles each select value is held; legal range 1..255.
- CNT_W, 8, width of the internal dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream offers in_data this cycle.
- in_data  input  4  word to be scanned.
- in_ready  output  1  block accepts a word this cycle.
- abort  input  1  synchronous cancel of the scan in progress.
- W  output  4  latched word, wired to the mux data inputs.
- S  output  2  select, wired to the mux select inputs.
- sample  output  1  one-cycle strobe: downstream samples the mux output this cycle.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse at the end of a complete scan.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, W=0, S=0, sample=0, done=0, busy=0, dwell counter=0, in_ready=1 on the first cycle after release.
- States: IDLE, SCAN, DONE. State is registered. All outputs except in_ready are registered; in_ready is decoded from state.
- IDLE:
  - in_ready=1; S holds its last value.
  - On in_valid & in_ready: W<=in_data, S<=first index (0), dwell<=0, go to SCAN.
  - in_data is ignored while in_valid=0.
- SCAN:
  - in_ready=0; in_valid is ignored and does not queue.
  - Each cycle dwell increments.
  - When dwell==DWELL-1: sample=1 that cycle, dwell<=0, and S advances to the next index.
  - When the sampled index is the last one (3), go to DONE instead of advancing.
  - W is constant for the whole scan.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Returns to IDLE; in_ready=1 in the following cycle.
  - S stays at the last index.
- Timing:
  - Accept edge is cycle 0.
  - S=0 is valid from cycle 1.
  - First sample occurs in cycle DWELL; sample for index k occurs in cycle (k+1)*DWELL.
  - done occurs in cycle 4*DWELL+1; the next accept is possible at cycle 4*DWELL+2.
- DWELL=1: sample is high for 4 consecutive cycles and S changes every cycle.
- abort:
  - In SCAN: next state is IDLE, sample=0, no done pulse, W retained.
  - In IDLE or DONE: abort has no effect; DONE still completes.
- abort and the last sample in the same cycle: abort wins, and that sample strobe is still emitted.
- Reset asserted mid-scan: everything clears immediately, no done pulse, and the partially scanned word is lost.
- Dwell counter never exceeds DWELL-1; there is no wrap-around beyond that.

Optional Feature:
- Macro: SCAN_MSB_FIRST_EN.
- Defined: first index=3, S sequence 3,2,1,0, last index=0 (MSB of W emitted first).
- Undefined: first index=0, S sequence 0,1,2,3, last index=3 (LSB first).
- Timing, strobes and handshake are identical in both builds.

Test Plan:
- Reset then idle (DWELL=1): hold rst_n=0 3 cycles, release -> W=0, S=0, sample=0, done=0, in_ready=1.
- Basic scan (DWELL=1): in_data=4'b1010 with in_valid for 1 cycle -> S=0,1,2,3 on cycles 1-4, sample high cycles 1-4, mux output samples 0,1,0,1, done in cycle 5, in_ready=1 in cycle 6.
- Dwell (DWELL=3): in_data=4'hC -> each S value held 3 cycles, sample in cycles 3,6,9,12 only, done in cycle 13.
- Busy rejection: second in_valid with in_data=4'h5 during the scan of 4'hC -> W stays 4'hC, no extra scan; a new accept of 4'h5 happens only once in_ready returns.
- Abort and reset: abort in cycle 2 of a DWELL=1 scan -> IDLE next cycle, no done. Separately, rst_n low mid-scan -> outputs zero immediately (asynchronously), no done pulse.
- Macro build (SCAN_MSB_FIRST_EN defined): in_data=4'b0001 -> S=3,2,1,0, samples 0,0,0,1, done in cycle 5.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Scans a latched 4-bit word through a 4:1 mux select, holding each index DWELL cycles.
// Optional build macro SCAN_MSB_FIRST_EN reverses the select order (3,2,1,0).
module mux_scan_sequencer #(
    parameter int DWELL = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       abort,
    output logic [3:0] W,
    output logic [1:0] S,
    output logic       sample,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    // With a one-cycle dwell every new index is sampled immediately.
    localparam logic             FIRST_HIT  = (DWELL == 1);

`ifdef SCAN_MSB_FIRST_EN
    localparam logic [1:0] FIRST_IDX = 2'd3;
    localparam logic [1:0] LAST_IDX  = 2'd0;
`else
    localparam logic [1:0] FIRST_IDX = 2'd0;
    localparam logic [1:0] LAST_IDX  = 2'd3;
`endif

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_dwell, w_dwell_nxt;
    logic [3:0]       r_w, w_w_nxt;
    logic [1:0]       r_s, w_s_nxt, w_s_step;
    logic             r_sample, w_sample_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_accept, w_dwell_end;

`ifdef SCAN_MSB_FIRST_EN
    assign w_s_step = r_s - 2'd1;
`else
    assign w_s_step = r_s + 2'd1;
`endif

    assign in_ready    = (r_state == ST_IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_dwell_end = (r_dwell == DWELL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dwell  <= '0;
            r_w      <= '0;
            r_s      <= '0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dwell  <= w_dwell_nxt;
            r_w      <= w_w_nxt;
            r_s      <= w_s_nxt;
            r_sample <= w_sample_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (abort)                                w_state_nxt = ST_IDLE;
                else if (w_dwell_end && r_s == LAST_IDX)  w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead so sample lines up with S.
    always_comb begin
        w_w_nxt      = r_w;
        w_s_nxt      = r_s;
        w_dwell_nxt  = r_dwell;
        w_sample_nxt = 1'b0;
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_done_nxt   = (w_state_nxt == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_w_nxt      = in_data;
                    w_s_nxt      = FIRST_IDX;
                    w_dwell_nxt  = '0;
                    w_sample_nxt = FIRST_HIT;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    w_dwell_nxt = '0;
                end else if (w_dwell_end) begin
                    w_dwell_nxt = '0;
                    if (r_s != LAST_IDX) begin
                        w_s_nxt      = w_s_step;
                        w_sample_nxt = FIRST_HIT;
                    end
                end else begin
                    w_dwell_nxt  = r_dwell + CNT_W'(1);
                    w_sample_nxt = ((r_dwell + CNT_W'(1)) == DWELL_LAST);
                end
            end
            default: w_dwell_nxt = '0;
        endcase
    end

    assign W      = r_w;
    assign S      = r_s;
    assign sample = r_sample;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: one DWELL=1 and one DWELL=3 instance checked against a cycle-timeline model.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       va = 1'b0, vb = 1'b0;
    logic [3:0] da = '0,   db = '0;
    logic       aa = 1'b0, ab = 1'b0;

    logic       rdy_a, rdy_b, smp_a, smp_b, bsy_a, bsy_b, dn_a, dn_b;
    logic [3:0] w_a, w_b;
    logic [1:0] s_a, s_b;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_w [2];
    logic [1:0] exp_s [2];

    logic       sel = 1'b0;
    logic       o_rdy, o_smp, o_bsy, o_dn;
    logic [3:0] o_w;
    logic [1:0] o_s;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_data(da), .in_ready(rdy_a),
        .abort(aa), .W(w_a), .S(s_a), .sample(smp_a), .busy(bsy_a), .done(dn_a)
    );

    mux_scan_sequencer #(.DWELL(3), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_data(db), .in_ready(rdy_b),
        .abort(ab), .W(w_b), .S(s_b), .sample(smp_b), .busy(bsy_b), .done(dn_b)
    );

    always_comb begin
        o_rdy = sel ? rdy_b : rdy_a;
        o_smp = sel ? smp_b : smp_a;
        o_bsy = sel ? bsy_b : bsy_a;
        o_dn  = sel ? dn_b  : dn_a;
        o_w   = sel ? w_b   : w_a;
        o_s   = sel ? s_b   : s_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scan order: the k-th index presented on S.
    function automatic logic [1:0] ord(input int k);
`ifdef SCAN_MSB_FIRST_EN
        return 2'(3 - k);
`else
        return 2'(k);
`endif
    endfunction

    task automatic set_in(input int which, input logic v, input logic [3:0] d, input logic a);
        if (which == 0) begin
            va = v; da = d; aa = a; vb = 1'b0; db = '0; ab = 1'b0;
        end else begin
            vb = v; db = d; ab = a; va = 1'b0; da = '0; aa = 1'b0;
        end
    endtask

    task automatic chk_idle(input string tag, input int which);
        chk({tag, "_rdy"}, o_rdy, 1'b1);
        chk({tag, "_busy"}, o_bsy, 1'b0);
        chk({tag, "_done"}, o_dn, 1'b0);
        chk({tag, "_sample"}, o_smp, 1'b0);
        chk({tag, "_W"}, o_w, exp_w[which]);
        chk({tag, "_S"}, o_s, exp_s[which]);
    endtask

    // junk: 0 none, 1 constant offer of 4'h5, 2 random offers during the scan
    task automatic scan(input int which, input logic [3:0] data, input int abort_cyc, input int junk);
        int d, n, k;
        logic [1:0] es;
        logic [3:0] jd;
        logic jv;
        d = (which == 0) ? 1 : 3;
        n = 4 * d;
        sel = (which != 0);
        @(negedge clk);
        chk_idle("pre", which);
        set_in(which, 1'b1, data, 1'b0);
        @(negedge clk);
        exp_w[which] = data;
        for (int c = 1; c <= n + 1; c++) begin
            if (c <= n) begin
                k  = (c - 1) / d;
                es = ord(k);
                chk("scan_S", o_s, es);
                chk("scan_W", o_w, data);
                chk("scan_busy", o_bsy, 1'b1);
                chk("scan_rdy", o_rdy, 1'b0);
                chk("scan_done", o_dn, 1'b0);
                chk("scan_sample", o_smp, (c % d) == 0);
                if ((c % d) == 0) chk("mux_out", o_w[o_s], data[es]);
            end else begin
                chk("done_pulse", o_dn, 1'b1);
                chk("done_busy", o_bsy, 1'b1);
                chk("done_sample", o_smp, 1'b0);
                chk("done_S", o_s, ord(3));
                chk("done_rdy", o_rdy, 1'b0);
            end
            jv = 1'b0;
            jd = 4'h0;
            if (junk == 1) begin
                jv = 1'b1; jd = 4'h5;
            end else if (junk == 2) begin
                jv = 1'($urandom % 2); jd = 4'($urandom);
            end
            set_in(which, jv, jd, c == abort_cyc);
            @(negedge clk);
            if (c == abort_cyc && c <= n) begin
                exp_s[which] = es;
                chk_idle("abort", which);
                set_in(which, 1'b0, 4'h0, 1'b0);
                return;
            end
        end
        exp_s[which] = ord(3);
        chk_idle("post", which);
        set_in(which, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic reset_mid(input int which, input logic [3:0] data, input int cyc);
        sel = (which != 0);
        @(negedge clk);
        set_in(which, 1'b1, data, 1'b0);
        @(negedge clk);
        set_in(which, 1'b0, 4'h0, 1'b0);
        repeat (cyc - 1) @(negedge clk);
        chk("midrst_busy_before", o_bsy, 1'b1);
        rst_n = 1'b0;
        #1;
        exp_w[0] = '0; exp_w[1] = '0;
        exp_s[0] = '0; exp_s[1] = '0;
        chk_idle("midrst", which);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4 * 3 + 2; i++) begin
            @(negedge clk);
            chk_idle("after_rst", which);
        end
    endtask

    initial begin
        int which, dw, ac;
        exp_w[0] = '0; exp_w[1] = '0;
        exp_s[0] = '0; exp_s[1] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        chk_idle("reset_a", 0);
        sel = 1'b1;
        chk_idle("reset_b", 1);

        scan(0, 4'b1010, 0, 0);
        scan(1, 4'hC, 0, 1);
        scan(1, 4'h5, 0, 0);
        scan(0, 4'b0001, 0, 0);
        scan(0, 4'($urandom), 2, 0);
        scan(0, 4'($urandom), 4, 2);
        scan(1, 4'($urandom), 12, 0);
        scan(0, 4'($urandom), 5, 0);
        reset_mid(1, 4'h9, 5);

        for (int i = 0; i < 24; i++) begin
            which = int'($urandom % 2);
            dw    = (which == 0) ? 1 : 3;
            ac    = ($urandom % 2) ? int'($urandom_range(1, 4 * dw + 1)) : 0;
            scan(which, 4'($urandom), ac, int'($urandom % 3));
            repeat ($urandom % 3) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
